// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: instruction field widths, decode-field extractors and fetch FSM states
package rv_fetch_pkg;
    localparam int INST_W = 32;
    localparam int OPCODE_W = 7;
    localparam int FUNCT_W = 4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    typedef enum logic [1:0] {RUN, DRAIN} fetch_state_t;
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INST_W-1:0] inst);
        return inst[6:0];
    endfunction
    // Packing matches the ALU_Control input encoding
    function automatic logic [FUNCT_W-1:0] get_funct(input logic [INST_W-1:0] inst);
        return {inst[30], inst[14:12]};
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO with flush; head entry is read combinationally
module fetch_buffer #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/fetch-request engine with redirect handling and a decode-side handshake
module instr_fetch_unit import rv_fetch_pkg::*; #(
    parameter int                  PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_W-1:0]   imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [INST_W-1:0]   out_inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  Funct
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = PC_WIDTH + INST_W;
    fetch_state_t state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_tail, target;
    logic [CW-1:0] outstanding, outstanding_next, drop, drop_next, count;
    logic req_fire, push, pop, full, empty;
    logic [EW-1:0] head;
    assign target = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    // Requests in flight plus words held may never exceed the buffer size
    assign imem_req_valid = !reset && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr = pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign push = imem_rsp_valid && drop == '0 && !redirect_valid;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    assign {out_pc, out_inst} = out_valid ? head : '0;
    assign opcode = get_opcode(out_inst);
    assign Funct = get_funct(out_inst);
    fetch_buffer #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_buf (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .din({pc_tail, imem_rsp_data}),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        drop_next = redirect_valid ? outstanding_next
                  : (imem_rsp_valid && drop != '0) ? drop - CW'(1) : drop;
        state_next = redirect_valid ? (outstanding_next != '0 ? DRAIN : RUN)
                   : (state == DRAIN && drop_next == '0) ? RUN : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc <= RESET_PC;
            pc_tail <= RESET_PC;
            outstanding <= '0;
            drop <= '0;
        end else begin
            state <= state_next;
            pc <= redirect_valid ? target : req_fire ? pc + PC_WIDTH'(4) : pc;
            pc_tail <= redirect_valid ? target : push ? pc_tail + PC_WIDTH'(4) : pc_tail;
            outstanding <= outstanding_next;
            drop <= drop_next;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && full));
    end
endmodule
